sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in parallel-out deserializing receiver: the receiving end of the team's serial shift chains. It collects a qualified serial bit stream into WIDTH-bit words, with optional framing resync and an optional parity bit. Completed words are held in a one-word output buffer and presented on a valid/ready handshake to the downstream parallel consumer.

## Interface
- WIDTH, 8: data bits per word, legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in this cycle.
- frame_start  input  1  synchronous resync; discards any partial word.
- data_out  output  WIDTH  completed word (holding register).
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word when data_valid & data_ready.
- busy  output  1  a partial word (≥1 bit) is in progress.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- parity_err  output  1  parity result for the word in data_out; valid while data_valid=1.

## Operation
- FSM states: IDLE (no bits captured), SHIFT (collecting data bits), PAR (awaiting the parity bit; present only with SIPO_RX_PARITY_EN).
- The bit counter is $clog2(WIDTH+1) bits wide and counts qualified data bits from 0 to WIDTH-1.
- Shift on each bit_valid cycle:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shreg <= {serial_in, shreg[WIDTH-1:1]}.
- IDLE -> SHIFT on the first bit_valid; the counter becomes 1.
- SHIFT, bit WIDTH-1 sampled:
  - Without parity: the word completes and the FSM returns to IDLE.
  - With parity: the FSM goes to PAR.
- PAR, bit_valid: the sampled bit is the parity bit; the word completes and the FSM goes to IDLE.
- Word completion:
  - If the buffer is empty, or is being consumed this same cycle, the holding register loads and data_valid is set.
  - Otherwise the new word is dropped, overrun pulses, and the buffer is unchanged.
- Handshake: data_valid falls on the cycle after data_valid & data_ready unless a new word completes that same cycle. data_out is stable while data_valid=1.
- frame_start:
  - Clears the counter and shreg state and forces IDLE.
  - If bit_valid is also high, that bit is taken as bit 0 and the FSM enters SHIFT with count 1.
  - Never affects the holding buffer.
- bit_valid gaps of any length are legal; the state holds.
- busy = (state != IDLE).

## Timing
- Reset (rst_n=0, asynchronous): data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0, FSM=IDLE, counter=0, shreg=0.
- Reset asserted mid-word discards the partial word and any buffered word.
- Latency: data_valid and data_out update on the clock edge that samples the final bit (the data bit, or the parity bit if enabled). They are visible in the cycle after that bit is presented.
- overrun is registered and asserted for exactly one cycle, aligned with the dropped word's completion edge.
- Throughput: one word per WIDTH (or WIDTH+1) bit_valid cycles. Back-to-back words need no idle cycle.
- frame_start has priority over word completion in the same cycle: no word is emitted.

## Configuration
- SIPO_RX_PARITY_EN defined:
  - Each word is followed by one even-parity bit.
  - parity_err = XOR of the WIDTH data bits and the parity bit, registered with data_out.
- SIPO_RX_PARITY_EN undefined:
  - The PAR state and parity logic are absent.
  - Words are WIDTH bits; parity_err is tied 0.

## Test plan
- WIDTH=8, MSB_FIRST=1: bits 1,0,1,1,0,0,1,0 with bit_valid=1 on consecutive cycles, data_ready=1 -> data_out=8'hB2, data_valid high for one cycle, overrun=0.
- MSB_FIRST=0, same bit sequence with random bit_valid gaps -> data_out=8'h4D; busy=1 from the first bit until completion.
- data_ready=0, two full words streamed (8'hB2 then 8'hFF) -> data_out stays 8'hB2, overrun pulses once at the second word's completion, data_valid stays 1.
- 4 bits sent, then frame_start with bit_valid=1 and serial_in=1, then 7 more bits 0 -> data_out=8'h80; the partial word is discarded.
- rst_n driven low after 5 bits -> all outputs 0 immediately. A subsequent 8 bits 8'hA5 -> data_out=8'hA5.
- With SIPO_RX_PARITY_EN: 8'hB2 plus parity 0 -> parity_err=0; 8'hB2 plus parity 1 -> parity_err=1.

Source files
------------

// File: rtl/sipo_rx_if.sv
// sipo_rx_if: bundle between the serial source, the sipo_rx receiver and the parallel consumer.
// master = source/consumer side, slave = receiver side.
interface sipo_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output serial_in, bit_valid, frame_start, data_ready,
        input  data_out, data_valid, busy, overrun, parity_err
    );

    modport slave (
        input  serial_in, bit_valid, frame_start, data_ready,
        output data_out, data_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx: deserializes a qualified serial bit stream into WIDTH-bit words behind a one-word buffer.
// Define SIPO_RX_PARITY_EN to expect and check an even-parity bit after every word.
module sipo_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    sipo_rx_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state;
    logic [CntW-1:0]  cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shreg_first;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             ovr;
    logic             accept;
`ifdef SIPO_RX_PARITY_EN
    logic             perr;
`endif

    // shreg_first is the register image after the first bit lands in an empty register
    always_comb begin
        if (MSB_FIRST) begin
            shreg_next  = {shreg[WIDTH-2:0], bus.serial_in};
            shreg_first = {{(WIDTH-1){1'b0}}, bus.serial_in};
        end else begin
            shreg_next  = {bus.serial_in, shreg[WIDTH-1:1]};
            shreg_first = {bus.serial_in, {(WIDTH-1){1'b0}}};
        end
    end

    // A completed word may load when the buffer is empty or drains on this same edge
    assign accept = !word_valid || bus.data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            shreg      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            ovr        <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            perr       <= 1'b0;
`endif
        end else begin
            ovr <= 1'b0;
            if (word_valid && bus.data_ready) begin
                word_valid <= 1'b0;
            end
            if (bus.frame_start) begin
                state <= StIdle;
                cnt   <= '0;
                shreg <= '0;
                if (bus.bit_valid) begin
                    state <= StShift;
                    cnt   <= CntW'(1);
                    shreg <= shreg_first;
                end
            end else if (bus.bit_valid) begin
                unique case (state)
                    StIdle: begin
                        state <= StShift;
                        cnt   <= CntW'(1);
                        shreg <= shreg_first;
                    end
                    StShift: begin
                        if (cnt == CntW'(WIDTH - 1)) begin
                            cnt <= '0;
`ifdef SIPO_RX_PARITY_EN
                            state <= StPar;
                            shreg <= shreg_next;
`else
                            state <= StIdle;
                            shreg <= '0;
                            if (accept) begin
                                word_out   <= shreg_next;
                                word_valid <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
`endif
                        end else begin
                            cnt   <= cnt + CntW'(1);
                            shreg <= shreg_next;
                        end
                    end
`ifdef SIPO_RX_PARITY_EN
                    StPar: begin
                        state <= StIdle;
                        shreg <= '0;
                        if (accept) begin
                            word_out   <= shreg;
                            word_valid <= 1'b1;
                            perr       <= (^shreg) ^ bus.serial_in;
                        end else begin
                            ovr <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = word_out;
    assign bus.data_valid = word_valid;
    assign bus.busy       = (state != StIdle);
    assign bus.overrun    = ovr;
`ifdef SIPO_RX_PARITY_EN
    assign bus.parity_err = perr;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: drives an MSB-first and an LSB-first receiver with identical streams and checks
// both against a bit-queue reference model of framing, buffering and overrun.
module tb_sipo_rx;
    localparam int unsigned WIDTH = 8;
`ifdef SIPO_RX_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(WIDTH)) if_m ();
    sipo_rx_if #(.WIDTH(WIDTH)) if_l ();

    sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
    sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

    int checks = 0;
    int failures = 0;

    // Reference model: bits of the frame in progress, plus the one-word buffer
    bit               m_bits[$];
    bit               m_full;
    bit               m_ovr;
    bit               m_perr;
    logic [WIDTH-1:0] m_word [2];

    // Observed outputs; index 0 = MSB-first DUT, 1 = LSB-first DUT
    logic [WIDTH-1:0] o_do   [2];
    logic             o_dv   [2];
    logic             o_busy [2];
    logic             o_ovr  [2];
    logic             o_perr [2];

    function automatic logic [WIDTH-1:0] pack(input bit msb);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (msb) w[WIDTH-1-i] = m_bits[i];
            else     w[i] = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_full    = 1'b0;
        m_ovr     = 1'b0;
        m_perr    = 1'b0;
        m_word[0] = '0;
        m_word[1] = '0;
    endtask

    task automatic model_clock(input bit sb, input bit bv, input bit fs, input bit rdy);
        bit par;
        m_ovr = 1'b0;
        if (m_full && rdy) m_full = 1'b0;
        if (fs) m_bits.delete();
        if (bv) m_bits.push_back(sb);
        if (m_bits.size() == FRAME) begin
            if (!m_full) begin
                m_full    = 1'b1;
                m_word[0] = pack(1'b1);
                m_word[1] = pack(1'b0);
                par = 1'b0;
                foreach (m_bits[i]) par ^= m_bits[i];
                m_perr = (FRAME > WIDTH) ? par : 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
            m_bits.delete();
        end
    endtask

    task automatic sample();
        o_do[0] = if_m.data_out;   o_do[1] = if_l.data_out;
        o_dv[0] = if_m.data_valid; o_dv[1] = if_l.data_valid;
        o_busy[0] = if_m.busy;     o_busy[1] = if_l.busy;
        o_ovr[0] = if_m.overrun;   o_ovr[1] = if_l.overrun;
        o_perr[0] = if_m.parity_err; o_perr[1] = if_l.parity_err;
    endtask

    // Entered at a falling edge; drives one cycle, updates the model, samples at the next fall
    task automatic step(input bit sb, input bit bv, input bit fs, input bit rdy);
        if_m.serial_in = sb; if_m.bit_valid = bv; if_m.frame_start = fs; if_m.data_ready = rdy;
        if_l.serial_in = sb; if_l.bit_valid = bv; if_l.frame_start = fs; if_l.data_ready = rdy;
        @(posedge clk);
        model_clock(sb, bv, fs, rdy);
        @(negedge clk);
        sample();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit par, input bit rdy,
                             input int max_gap);
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, 1'b0, rdy);
            step(w[i], 1'b1, 1'b0, rdy);
        end
        if (FRAME > WIDTH) step(par, 1'b1, 1'b0, rdy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        sample();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_do[k] !== '0 || o_dv[k] !== 1'b0 || o_busy[k] !== 1'b0 ||
                o_ovr[k] !== 1'b0 || o_perr[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d got do=%h dv=%b busy=%b ovr=%b perr=%b exp all 0",
                         k, o_do[k], o_dv[k], o_busy[k], o_ovr[k], o_perr[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] w;
        w = 8'hB2;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            step(w[i], 1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_busy[k] !== (m_bits.size() != 0) || o_ovr[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_busy dut%0d bit%0d got busy=%b ovr=%b exp busy=%b ovr=0",
                             k, i, o_busy[k], o_ovr[k], m_bits.size() != 0);
                end
            end
        end
        if (FRAME > WIDTH) step(^w, 1'b1, 1'b0, 1'b1);
        checks++;
        if (o_dv[0] !== 1'b1 || o_do[0] !== 8'hB2) begin
            failures++;
            $display("FAIL basic_msb got dv=%b do=%h exp dv=1 do=b2", o_dv[0], o_do[0]);
        end
        checks++;
        if (o_dv[1] !== 1'b1 || o_do[1] !== 8'h4D) begin
            failures++;
            $display("FAIL basic_lsb got dv=%b do=%h exp dv=1 do=4d", o_dv[1], o_do[1]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_dv[k] !== 1'b0) begin
                failures++;
                $display("FAIL basic_consume dut%0d got dv=%b exp dv=0", k, o_dv[k]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] w;
        w = 8'hB2;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, 3)) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                checks++;
                if (o_busy[1] !== (i != int'(WIDTH) - 1)) begin
                    failures++;
                    $display("FAIL gaps_busy bit%0d got busy=%b exp=%b", i, o_busy[1],
                             i != int'(WIDTH) - 1);
                end
            end
            step(w[i], 1'b1, 1'b0, 1'b1);
        end
        if (FRAME > WIDTH) step(^w, 1'b1, 1'b0, 1'b1);
        checks++;
        if (o_dv[1] !== 1'b1 || o_do[1] !== 8'h4D || o_busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL gaps_word got dv=%b do=%h busy=%b exp dv=1 do=4d busy=0",
                     o_dv[1], o_do[1], o_busy[1]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        logic [WIDTH-1:0] words [2];
        int pulses;
        words[0] = 8'hB2;
        words[1] = 8'hFF;
        pulses = 0;
        for (int n = 0; n < 2; n++) begin
            for (int i = int'(FRAME) - 1; i >= 0; i--) begin
                step((i >= int'(FRAME - WIDTH)) ? words[n][i - int'(FRAME - WIDTH)] : ^words[n],
                     1'b1, 1'b0, 1'b0);
                if (o_ovr[0]) pulses++;
                checks++;
                if (o_ovr[0] !== m_ovr || o_ovr[1] !== m_ovr) begin
                    failures++;
                    $display("FAIL overrun_cycle w%0d b%0d got %b/%b exp %b", n, i,
                             o_ovr[0], o_ovr[1], m_ovr);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (o_ovr[0]) pulses++;
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL overrun_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (o_dv[0] !== 1'b1 || o_do[0] !== 8'hB2 || o_do[1] !== 8'h4D) begin
            failures++;
            $display("FAIL overrun_hold got dv=%b do=%h/%h exp dv=1 do=b2/4d",
                     o_dv[0], o_do[0], o_do[1]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_dv[0] !== 1'b0 || o_dv[1] !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drain got dv=%b/%b exp 0/0", o_dv[0], o_dv[1]);
        end
    endtask

    task automatic test_resync();
        repeat (4) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (o_busy[0] !== 1'b1 || o_dv[0] !== 1'b0) begin
            failures++;
            $display("FAIL resync_start got busy=%b dv=%b exp busy=1 dv=0", o_busy[0], o_dv[0]);
        end
        repeat (WIDTH - 1) step(1'b0, 1'b1, 1'b0, 1'b1);
        if (FRAME > WIDTH) step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (o_dv[0] !== 1'b1 || o_do[0] !== 8'h80 || o_do[1] !== 8'h01) begin
            failures++;
            $display("FAIL resync_word got dv=%b do=%h/%h exp dv=1 do=80/01",
                     o_dv[0], o_do[0], o_do[1]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_word(8'h3C, ^8'h3C, 1'b0, 0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        sample();
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_do[k] !== '0 || o_dv[k] !== 1'b0 || o_busy[k] !== 1'b0 ||
                o_ovr[k] !== 1'b0 || o_perr[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid dut%0d got do=%h dv=%b busy=%b ovr=%b perr=%b exp 0",
                         k, o_do[k], o_dv[k], o_busy[k], o_ovr[k], o_perr[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hA5, ^8'hA5, 1'b1, 1);
        checks++;
        if (o_dv[0] !== 1'b1 || o_do[0] !== 8'hA5 || o_do[1] !== m_word[1]) begin
            failures++;
            $display("FAIL reset_mid_word got dv=%b do=%h/%h exp dv=1 do=a5/%h",
                     o_dv[0], o_do[0], o_do[1], m_word[1]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_parity();
        send_word(8'hB2, 1'b0, 1'b1, 0);
        checks++;
        if (o_dv[0] !== 1'b1 || o_perr[0] !== 1'b0 || o_perr[1] !== 1'b0) begin
            failures++;
            $display("FAIL parity_good got dv=%b perr=%b/%b exp dv=1 perr=0/0",
                     o_dv[0], o_perr[0], o_perr[1]);
        end
        send_word(8'hB2, 1'b1, 1'b1, 0);
        checks++;
        if (o_dv[0] !== 1'b1 || o_perr[0] !== 1'b1 || o_perr[1] !== 1'b1 || o_do[0] !== 8'hB2)
        begin
            failures++;
            $display("FAIL parity_bad got dv=%b perr=%b/%b do=%h exp dv=1 perr=1/1 do=b2",
                     o_dv[0], o_perr[0], o_perr[1], o_do[0]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit sb, bv, fs, rdy;
        for (int c = 0; c < 800; c++) begin
            sb  = 1'($urandom_range(0, 1));
            bv  = ($urandom_range(0, 3) != 0);
            fs  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(sb, bv, fs, rdy);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_do[k] !== m_word[k] || o_dv[k] !== m_full ||
                    o_busy[k] !== (m_bits.size() != 0) || o_ovr[k] !== m_ovr ||
                    o_perr[k] !== m_perr) begin
                    failures++;
                    $display("FAIL random c%0d dut%0d got do=%h dv=%b busy=%b ovr=%b perr=%b %s",
                             c, k, o_do[k], o_dv[k], o_busy[k], o_ovr[k], o_perr[k],
                             $sformatf("exp do=%h dv=%b busy=%b ovr=%b perr=%b", m_word[k],
                                       m_full, m_bits.size() != 0, m_ovr, m_perr));
                end
            end
        end
    endtask

    initial begin
        if_m.serial_in = 1'b0; if_m.bit_valid = 1'b0; if_m.frame_start = 1'b0;
        if_m.data_ready = 1'b0;
        if_l.serial_in = 1'b0; if_l.bit_valid = 1'b0; if_l.frame_start = 1'b0;
        if_l.data_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_resync();
        test_reset_mid();
`ifdef SIPO_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
